// File: rtl/dmem_pkg.sv
// Shared constants and types for the handshaked byte-addressable data memory.
package dmem_pkg;

  // RV32I load/store size codes carried on funct3
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Number of 32-bit words preloaded with i+1 at time zero
  localparam int PRELOAD_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: legality check, byte enables, store lane
// steering and load extraction/extension. All lanes are relative to the
// access address, so lane 0 is byte[addr].
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rbytes,
  output logic        err,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] rdata
);

  // Decode size/sign, flag misalignment and illegal codes, then squash on error
  always_comb begin
    err    = 1'b0;
    be     = 4'b0000;
    rdata  = 32'h0;
    wlanes = wdata;
    case (funct3)
      F3_B: begin
        be    = 4'b0001;
        rdata = {{24{rbytes[7]}}, rbytes[7:0]};
      end
      F3_BU: begin
        err   = we;
        be    = 4'b0001;
        rdata = {24'h0, rbytes[7:0]};
      end
      F3_H: begin
        err   = addr_lo[0];
        be    = 4'b0011;
        rdata = {{16{rbytes[15]}}, rbytes[15:0]};
      end
      F3_HU: begin
        err   = addr_lo[0] | we;
        be    = 4'b0011;
        rdata = {16'h0, rbytes[15:0]};
      end
      F3_W: begin
        err   = |addr_lo;
        be    = 4'b1111;
        rdata = rbytes;
      end
      default: err = 1'b1;
    endcase
    if (err || !we) be = 4'b0000;
    if (err || we) rdata = 32'h0;
  end

endmodule

// File: rtl/data_memory_hs.sv
// Byte-addressable little-endian data memory with a valid/ready request
// channel, a one-cycle response strobe and configurable wait states.
// The access commits on the edge that enters RESP.
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef logic [7:0] mem_t [DEPTH];

  function automatic mem_t preload_image();
    mem_t        img;
    logic [31:0] word;
    for (int i = 0; i < DEPTH; i++) img[ADDR_W'(i)] = 8'h00;
    for (int w = 0; w < PRELOAD_WORDS; w++) begin
      word = 32'(w + 1);
      if (4 * w + 3 < DEPTH) begin
        for (int k = 0; k < 4; k++) img[ADDR_W'(4 * w + k)] = word[8*k +: 8];
      end
    end
    return img;
  endfunction

  mem_t mem_q = preload_image();

  dmem_state_t       state_q, state_d;
  logic [2:0]        cnt_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              accept, commit;
  logic              acc_we;
  logic [2:0]        acc_f3;
  logic [ADDR_W-1:0] acc_addr, acc_a1, acc_a2, acc_a3;
  logic [31:0]       acc_wdata;
  logic [31:0]       rbytes;
  logic              fmt_err;
  logic [3:0]        fmt_be;
  logic [31:0]       fmt_wlanes, fmt_rdata;

  assign req_ready  = rst_n && (state_q != WAIT);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);

  // With no wait states the commit edge is the accept edge, so the live
  // request is used; otherwise the latched copy is.
  always_comb begin
    acc_we    = we_q;
    acc_f3    = f3_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (WAIT_STATES == 0) begin
      acc_we    = req_we;
      acc_f3    = req_funct3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  // Byte addresses of the four lanes; wrap is harmless because only
  // aligned accesses ever enable the upper lanes.
  always_comb begin
    acc_a1 = acc_addr + ADDR_W'(1);
    acc_a2 = acc_addr + ADDR_W'(2);
    acc_a3 = acc_addr + ADDR_W'(3);
    rbytes = {mem_q[acc_a3], mem_q[acc_a2], mem_q[acc_a1], mem_q[acc_addr]};
  end

  dmem_lane_fmt u_fmt (
    .we      (acc_we),
    .funct3  (acc_f3),
    .addr_lo (acc_addr[1:0]),
    .wdata   (acc_wdata),
    .rbytes  (rbytes),
    .err     (fmt_err),
    .be      (fmt_be),
    .wlanes  (fmt_wlanes),
    .rdata   (fmt_rdata)
  );

  // Next-state decode; RESP accepts again for back-to-back accesses
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        else        state_d = IDLE;
      end
      WAIT:    if (cnt_q == 3'd1) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over a coinciding commit, so the store is dropped
  assign commit = rst_n && (state_d == RESP);

  // State register and wait-state down-counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      if (accept)                             cnt_q <= 3'(WAIT_STATES);
      else if (state_q == WAIT && cnt_q != 0) cnt_q <= cnt_q - 3'd1;
    end
  end

  // Request latch, loaded on every handshake
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Response data/error captured on the commit edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_rdata <= fmt_rdata;
      resp_err   <= fmt_err;
    end
  end

  // Byte array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (commit) begin
      if (fmt_be[0]) mem_q[acc_addr] <= fmt_wlanes[7:0];
      if (fmt_be[1]) mem_q[acc_a1]   <= fmt_wlanes[15:8];
      if (fmt_be[2]) mem_q[acc_a2]   <= fmt_wlanes[23:16];
      if (fmt_be[3]) mem_q[acc_a3]   <= fmt_wlanes[31:24];
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Scoreboard bench: two instances (0 and 3 wait states). Stimulus pushes the
// expected response; a negedge monitor pops and compares each response.
module tb_data_memory_hs;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [7:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  // Free-running cycle count used to check response latency
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_hs #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0])
  );

  data_memory_hs #(.ADDR_W(8), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1])
  );

  task automatic mon(input int s);
    exp_t e;
    bit   empty;
    if (resp_valid[s]) begin
      n_checks++;
      empty = (s == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        $display("FAIL unexpected_resp dut%0d: got rdata=%h err=%b with nothing outstanding",
                 s, resp_rdata[s], resp_err[s]);
      end else begin
        e = (s == 0) ? q0.pop_front() : q1.pop_front();
        if (resp_rdata[s] === e.rdata && resp_err[s] === e.err && cyc == e.cyc) begin
          n_pass++;
        end else begin
          $display("FAIL %s dut%0d: got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                   e.name, s, resp_rdata[s], resp_err[s], cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  // Response monitor for both instances
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic issue(input int s, input logic we, input logic [2:0] f3,
                       input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input bit want_resp, input string name, output int acc_cyc);
    exp_t e;
    int   guard;
    @(negedge clk);
    req_valid[s]  = 1'b1;
    req_we[s]     = we;
    req_funct3[s] = f3;
    req_addr[s]   = addr;
    req_wdata[s]  = wdata;
    guard = 0;
    while (!req_ready[s] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_checks++;
      $display("FAIL ready_timeout %s dut%0d: req_ready stayed %b, want 1", name, s, req_ready[s]);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid[s] = 1'b0;
    if (want_resp) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = acc_cyc + ((s == 0) ? 0 : 3);
      e.name  = name;
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b, want %b", name, got, want);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b;
    for (int s = 0; s < 2; s++) begin
      rst_n[s]      = 1'b0;
      req_valid[s]  = 1'b0;
      req_we[s]     = 1'b0;
      req_funct3[s] = 3'd0;
      req_addr[s]   = 8'h0;
      req_wdata[s]  = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (resp_valid[s] === 1'b0 && resp_rdata[s] === 32'h0 && resp_err[s] === 1'b0 &&
          req_ready[s] === 1'b0)
        n_pass++;
      else
        $display("FAIL reset_state dut%0d: got valid=%b rdata=%h err=%b ready=%b, want 0/0/0/0",
                 s, resp_valid[s], resp_rdata[s], resp_err[s], req_ready[s]);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Zero wait states: back-to-back directed vectors
    issue(0, 0, 3'd2, 8'h04, 32'h0,        32'h00000002, 0, 1, "lw_04", a);
    issue(0, 1, 3'd2, 8'h20, 32'h80FF7F01, 32'h0,        0, 1, "sw_20", a);
    issue(0, 0, 3'd0, 8'h20, 32'h0,        32'h00000001, 0, 1, "lb_20", a);
    issue(0, 0, 3'd0, 8'h23, 32'h0,        32'hFFFFFF80, 0, 1, "lb_23", a);
    issue(0, 0, 3'd4, 8'h23, 32'h0,        32'h00000080, 0, 1, "lbu_23", a);
    issue(0, 0, 3'd1, 8'h22, 32'h0,        32'hFFFF80FF, 0, 1, "lh_22", a);
    issue(0, 0, 3'd5, 8'h22, 32'h0,        32'h000080FF, 0, 1, "lhu_22", a);
    issue(0, 1, 3'd0, 8'h05, 32'h123456AB, 32'h0,        0, 1, "sb_05", a);
    issue(0, 0, 3'd2, 8'h04, 32'h0,        32'h0000AB02, 0, 1, "lw_04_after_sb", a);
    issue(0, 0, 3'd2, 8'h06, 32'h0,        32'h0,        1, 1, "lw_06_misaligned", a);
    issue(0, 0, 3'd1, 8'h01, 32'h0,        32'h0,        1, 1, "lh_01_misaligned", a);
    issue(0, 0, 3'd3, 8'h00, 32'h0,        32'h0,        1, 1, "funct3_3", a);
    issue(0, 1, 3'd4, 8'h04, 32'hFFFFFFFF, 32'h0,        1, 1, "store_bu_illegal", a);
    issue(0, 1, 3'd2, 8'h05, 32'hFFFFFFFF, 32'h0,        1, 1, "sw_05_misaligned", a);
    issue(0, 0, 3'd2, 8'h04, 32'h0,        32'h0000AB02, 0, 1, "lw_04_after_errs", a);
    issue(0, 1, 3'd1, 8'h10, 32'h1234CDEF, 32'h0,        0, 1, "sh_10", a);
    issue(0, 0, 3'd2, 8'h10, 32'h0,        32'h0000CDEF, 0, 1, "lw_10_after_sh", a);
    issue(0, 0, 3'd1, 8'h10, 32'h0,        32'hFFFFCDEF, 0, 1, "lh_10", a);
    issue(0, 0, 3'd2, 8'h1C, 32'h0,        32'h00000008, 0, 1, "lw_1c_last_preload", a);
    issue(0, 0, 3'd5, 8'h04, 32'h0,        32'h0000AB02, 0, 1, "lhu_04", a);
    repeat (4) @(negedge clk);

    // Three wait states: ready low for 3 cycles, then back-to-back from RESP
    issue(1, 0, 3'd2, 8'h04, 32'h0, 32'h00000002, 0, 1, "ws3_lw_04", a);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit($sformatf("ws3_ready_low_%0d", k), req_ready[1], 1'b0);
    end
    issue(1, 0, 3'd2, 8'h08, 32'h0, 32'h00000003, 0, 1, "ws3_lw_08", b);
    n_checks++;
    if (b - a == 4) n_pass++;
    else $display("FAIL ws3_no_gap: accept spacing %0d cycles, want 4", b - a);
    issue(1, 1, 3'd2, 8'h0C, 32'h11223344, 32'h0,          0, 1, "ws3_sw_0c", a);
    issue(1, 0, 3'd2, 8'h0C, 32'h0,        32'h11223344,   0, 1, "ws3_lw_0c", a);
    repeat (6) @(negedge clk);

    // Reset while a store is waiting: no response, store discarded
    issue(1, 1, 3'd2, 8'h08, 32'hDEADBEEF, 32'h0, 0, 0, "ws3_sw_08_reset", a);
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    check_bit("ws3_ready_in_reset", req_ready[1], 1'b0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    issue(1, 0, 3'd2, 8'h08, 32'h0, 32'h00000003, 0, 1, "ws3_lw_08_after_reset", a);

    repeat (10) @(negedge clk);
    n_checks++;
    if (q0.size() == 0 && q1.size() == 0) n_pass++;
    else $display("FAIL outstanding_responses: got %0d/%0d pending, want 0/0", q0.size(), q1.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory_hs.md
# data_memory_hs

Parametrised, synchronous, byte-addressable data memory for the MEM stage, with a valid/ready request channel, a valid response channel, configurable wait states, and RV32I sub-word access (LB/LH/LW/LBU/LHU, SB/SH/SW). Storage is little-endian, byte-wide. Misaligned and illegal-size accesses return an error response instead of silently corrupting memory. The pipeline stalls on `req_ready`/`resp_valid`.

## Interface
- `ADDR_W`, 8, byte-address width; depth = 2**ADDR_W bytes; legal 4..16.
- `WAIT_STATES`, 0, extra cycles between accept and response; legal 0..7.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; handshake when `req_valid && req_ready` at a rising edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I size/sign code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  load result, extended; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal funct3; qualified by `resp_valid`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On accept, latch we/funct3/addr/wdata. Go to WAIT with counter=WAIT_STATES if WAIT_STATES>0, otherwise go to RESP.
- WAIT: `req_ready`=0. Counter decrements each cycle. Go to RESP on the edge where counter==1.
- RESP: `resp_valid`=1 and `req_ready`=1. An accept in RESP re-enters WAIT or RESP as above, giving back-to-back accesses. Otherwise go to IDLE.
- Commit: the memory access happens on the edge that enters RESP. Store bytes are written and load data is captured into `resp_rdata`/`resp_err` on that edge.
- Load format:
  - B: sign-extend byte[addr].
  - BU: zero-extend byte[addr].
  - H: sign-extend {byte[addr+1], byte[addr]}.
  - HU: zero-extend {byte[addr+1], byte[addr]}.
  - W: {byte[a+3], byte[a+2], byte[a+1], byte[a]}.
- Store format:
  - funct3 0 writes `wdata[7:0]`.
  - funct3 1 writes `wdata[15:0]`.
  - funct3 2 writes all 32 bits, little-endian.
  - Store with funct3 4/5 is illegal.
- Errors:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - funct3 ∈ {3,6,7}.
  - Store with funct3 4/5.
  - Response: `resp_err`=1, `resp_rdata`=0, no bytes written.
- Aligned accesses never exceed the array, so no address wrap is needed.
- Preload at time zero: word i (bytes 4i..4i+3) = i+1 for i=0..7, little-endian. All other bytes are 0.
- Reset:
  - Memory contents are not touched.
  - State goes to IDLE, counter to 0.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `req_ready` is forced 0 while `rst_n`=0.
  - A reset in WAIT drops the latched store uncommitted. A reset coinciding with the commit edge also discards the store (reset wins).

## Timing
- Request accepted at edge N. `resp_valid` is high in the cycle after edge N+WAIT_STATES.
- Load-to-use latency is WAIT_STATES+1 cycles.
- Throughput: 1 access/cycle at WAIT_STATES=0, otherwise 1 per WAIT_STATES+1 cycles.
- Outputs are all registered or state-decoded. There is no combinational path from req_* to resp_*.
- `req_ready` is a decode of state only. It does not depend on `req_valid`.
- Read-after-write to the same address in the next accepted request returns the new data, because the write committed one edge earlier.

## Structure
- `dmem_pkg` holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state enum `dmem_state_t` {IDLE, WAIT, RESP}.
  - the preload word count (8).
- One sub-module, `dmem_lane_fmt`, combinational. It does the alignment check, byte-enable generation, store lane steering and load extraction/extension. The top block holds the FSM, counter, request latch and byte array.

## Test plan
- After reset, a LW at 0x04 (WAIT_STATES=0) → `resp_valid` one cycle later, `resp_rdata`=0x00000002, `resp_err`=0.
- SW 0x80FF7F01 at 0x20, then LB 0x20 → 0x00000001; LB 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080; LH 0x22 → 0xFFFF80FF; LHU 0x22 → 0x000080FF.
- SB 0xAB at 0x05, then LW 0x04 → 0x0000AB02.
- LW 0x06, LH 0x01, and funct3=3 each → `resp_err`=1, `rdata`=0. A following LW 0x04 still returns the prior value.
- WAIT_STATES=3: accept at edge N → `req_ready`=0 for 3 cycles, then `resp_valid` after edge N+3. Back-to-back accepts in RESP give no idle gap.
- Reset asserted while a SW 0xDEADBEEF at 0x08 is in WAIT → no response. After reset, LW 0x08 returns 0x00000003.
